// File: rtl/usb_setup_decoder.sv
// Collects the 8-byte SETUP data stage, decodes request fields, and owns the device address.
// Latency: req_valid/req_err one cycle after rx_end (or timeout); the input stream has no backpressure.
module usb_setup_decoder #(
    parameter int SETUP_LEN = 8,
    parameter int ADDR_W    = 7,
    parameter int TIMEOUT   = 4800
) (
    input  logic              clk_48,
    input  logic              rst_n,
    input  logic              usb_rst,
    input  logic              setup,
    input  logic [7:0]        rx_data,
    input  logic              rx_strobe,
    input  logic              rx_end,
    input  logic              rx_crc_ok,
    input  logic              status_done,
    output logic              req_valid,
    output logic              req_err,
    output logic              busy,
    output logic [7:0]        bm_request_type,
    output logic [7:0]        b_request,
    output logic [15:0]       w_value,
    output logic [15:0]       w_index,
    output logic [15:0]       w_length,
    output logic [ADDR_W-1:0] dev_addr
);

    localparam int CNT_W = $clog2(SETUP_LEN + 2);
    localparam int TO_W  = $clog2(TIMEOUT);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TO_W-1:0]            idle_q, idle_d;
    logic [SETUP_LEN-1:0][7:0]  shadow_q, shadow_d;
    logic                       valid_q, valid_d;
    logic                       err_q, err_d;
    logic [7:0]                 bmrt_q, bmrt_d;
    logic [7:0]                 breq_q, breq_d;
    logic [15:0]                wval_q, wval_d;
    logic [15:0]                widx_q, widx_d;
    logic [15:0]                wlen_q, wlen_d;
    logic                       pend_q, pend_d;
    logic [ADDR_W-1:0]          pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]          dev_addr_q, dev_addr_d;
    logic                       byte_in;
    logic                       timeout;
    logic                       good;

    assign byte_in = rx_strobe & setup;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        shadow_d    = shadow_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        bmrt_d      = bmrt_q;
        breq_d      = breq_q;
        wval_d      = wval_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        dev_addr_d  = dev_addr_q;
        timeout     = 1'b0;
        good        = 1'b0;

        if (usb_rst) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            idle_d      = '0;
            bmrt_d      = '0;
            breq_d      = '0;
            wval_d      = '0;
            widx_d      = '0;
            wlen_d      = '0;
            pend_d      = 1'b0;
            pend_addr_d = '0;
            dev_addr_d  = '0;
        end else begin
            if (byte_in) begin
                idle_d = '0;
                if (state_q == S_IDLE) begin
                    state_d     = S_COLLECT;
                    cnt_d       = CNT_W'(1);
                    shadow_d[0] = rx_data;
                end else begin
                    for (int i = 0; i < SETUP_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) shadow_d[i] = rx_data;
                    end
                    // Saturating one past full marks an overrun without wrapping.
                    if (cnt_q != CNT_W'(SETUP_LEN + 1)) cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (state_q == S_COLLECT) begin
                if (idle_q == TO_W'(TIMEOUT - 1)) timeout = 1'b1;
                else                              idle_d  = idle_q + TO_W'(1);
            end

            if (status_done && pend_q) begin
                dev_addr_d = pend_addr_q;
                pend_d     = 1'b0;
            end

            // state_d already reflects a byte taken this cycle, so rx_end sees it counted.
            if (rx_end && state_d == S_COLLECT) begin
                good    = (cnt_d == CNT_W'(SETUP_LEN)) && rx_crc_ok;
                state_d = S_IDLE;
                cnt_d   = '0;
                idle_d  = '0;
                if (good) begin
                    valid_d = 1'b1;
                    bmrt_d  = shadow_d[0];
                    breq_d  = shadow_d[1];
                    wval_d  = {shadow_d[3], shadow_d[2]};
                    widx_d  = {shadow_d[5], shadow_d[4]};
                    wlen_d  = {shadow_d[7], shadow_d[6]};
                    if (shadow_d[0] == 8'h00 && shadow_d[1] == 8'h05) begin
                        pend_d      = 1'b1;
                        pend_addr_d = shadow_d[2][ADDR_W-1:0];
                    end else begin
                        pend_d = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (timeout) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idle_d  = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            shadow_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            bmrt_q      <= '0;
            breq_q      <= '0;
            wval_q      <= '0;
            widx_q      <= '0;
            wlen_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            dev_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            shadow_q    <= shadow_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            bmrt_q      <= bmrt_d;
            breq_q      <= breq_d;
            wval_q      <= wval_d;
            widx_q      <= widx_d;
            wlen_q      <= wlen_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            dev_addr_q  <= dev_addr_d;
        end
    end

    assign req_valid       = valid_q;
    assign req_err         = err_q;
    assign busy            = (state_q == S_COLLECT);
    assign bm_request_type = bmrt_q;
    assign b_request       = breq_q;
    assign w_value         = wval_q;
    assign w_index         = widx_q;
    assign w_length        = wlen_q;
    assign dev_addr        = dev_addr_q;

endmodule

// File: tb/tb_usb_setup_decoder.sv
// Directed bench for usb_setup_decoder: table of packets plus hand sequences for address, timeout and reset.
module tb_usb_setup_decoder;

    logic        clk_48 = 1'b0;
    logic        rst_n;
    logic        usb_rst;
    logic        setup;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic        rx_end;
    logic        rx_crc_ok;
    logic        status_done;
    logic        req_valid;
    logic        req_err;
    logic        busy;
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_value;
    logic [15:0] w_index;
    logic [15:0] w_length;
    logic [6:0]  dev_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int n_vpulse = 0;
    int n_epulse = 0;
    int n_both   = 0;

    usb_setup_decoder dut (
        .clk_48          (clk_48),
        .rst_n           (rst_n),
        .usb_rst         (usb_rst),
        .setup           (setup),
        .rx_data         (rx_data),
        .rx_strobe       (rx_strobe),
        .rx_end          (rx_end),
        .rx_crc_ok       (rx_crc_ok),
        .status_done     (status_done),
        .req_valid       (req_valid),
        .req_err         (req_err),
        .busy            (busy),
        .bm_request_type (bm_request_type),
        .b_request       (b_request),
        .w_value         (w_value),
        .w_index         (w_index),
        .w_length        (w_length),
        .dev_addr        (dev_addr)
    );

    always #5 clk_48 = ~clk_48;

    always @(negedge clk_48) begin
        if (req_valid) n_vpulse++;
        if (req_err)   n_epulse++;
        if (req_valid && req_err) n_both++;
    end

    // pk holds bytes in transmission order, byte 0 in the top octet.
    typedef struct {
        logic [71:0] pk;
        int          n;
        bit          crc;
        bit          end_last;
        bit          exp_v;
        bit          exp_e;
        logic [7:0]  bm;
        logic [7:0]  br;
        logic [15:0] wv;
        logic [15:0] wi;
        logic [15:0] wl;
        logic [6:0]  addr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: rx_end after the bytes, 1: rx_end with the last byte, 2: no rx_end.
    task automatic send_pkt(input logic [71:0] pk, input int n, input bit crc, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_48);
            setup     = 1'b1;
            rx_strobe = 1'b1;
            rx_data   = pk[71-8*i -: 8];
            if (mode == 1 && i == n - 1) begin
                rx_end    = 1'b1;
                rx_crc_ok = crc;
            end
        end
        @(negedge clk_48);
        rx_strobe = 1'b0;
        rx_end    = 1'b0;
        if (mode == 0) begin
            rx_end    = 1'b1;
            rx_crc_ok = crc;
            @(negedge clk_48);
            rx_end = 1'b0;
        end
        setup     = 1'b0;
        rx_crc_ok = 1'b0;
    endtask

    task automatic chk_fields(input string tag, input logic [7:0] bm, input logic [7:0] br,
                              input logic [15:0] wv, input logic [15:0] wi, input logic [15:0] wl);
        chk({tag, ".bm"}, 32'(bm_request_type), 32'(bm));
        chk({tag, ".br"}, 32'(b_request), 32'(br));
        chk({tag, ".wv"}, 32'(w_value), 32'(wv));
        chk({tag, ".wi"}, 32'(w_index), 32'(wi));
        chk({tag, ".wl"}, 32'(w_length), 32'(wl));
    endtask

    initial begin
        int  nv, ne;
        bit  seen;

        vecs[0] = '{72'h80_06_00_01_00_00_12_00_00, 8, 1, 0, 1, 0, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 7'h00};
        vecs[1] = '{72'h81_0A_34_12_78_56_9A_00_00, 7, 1, 0, 0, 1, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 7'h00};
        vecs[2] = '{72'h81_0A_34_12_78_56_9A_BC_DE, 9, 1, 0, 0, 1, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 7'h00};
        vecs[3] = '{72'h81_0A_34_12_78_56_9A_BC_00, 8, 0, 0, 0, 1, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012, 7'h00};
        vecs[4] = '{72'hC1_01_EF_BE_AD_DE_04_00_00, 8, 1, 1, 1, 0, 8'hC1, 8'h01, 16'hBEEF, 16'hDEAD, 16'h0004, 7'h00};
        vecs[5] = '{72'h00_05_2A_00_00_00_00_00_00, 8, 1, 0, 1, 0, 8'h00, 8'h05, 16'h002A, 16'h0000, 16'h0000, 7'h00};

        rst_n = 1'b0; usb_rst = 1'b0; setup = 1'b0; rx_data = 8'h00; rx_strobe = 1'b0;
        rx_end = 1'b0; rx_crc_ok = 1'b0; status_done = 1'b0;
        repeat (3) @(negedge clk_48);
        chk("rst.valid", 32'(req_valid), 32'd0);
        chk("rst.err", 32'(req_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.addr", 32'(dev_addr), 32'd0);
        chk_fields("rst", 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_48);

        for (int v = 0; v < 6; v++) begin
            send_pkt(vecs[v].pk, vecs[v].n, vecs[v].crc, vecs[v].end_last ? 1 : 0);
            chk($sformatf("v%0d.valid", v), 32'(req_valid), 32'(vecs[v].exp_v));
            chk($sformatf("v%0d.err", v), 32'(req_err), 32'(vecs[v].exp_e));
            chk_fields($sformatf("v%0d", v), vecs[v].bm, vecs[v].br, vecs[v].wv, vecs[v].wi, vecs[v].wl);
            chk($sformatf("v%0d.addr", v), 32'(dev_addr), 32'(vecs[v].addr));
            @(negedge clk_48);
            chk($sformatf("v%0d.width", v), 32'({req_valid, req_err}), 32'd0);
            chk($sformatf("v%0d.busy", v), 32'(busy), 32'd0);
        end

        // SET_ADDRESS from vecs[5] takes effect only after status_done.
        repeat (3) @(negedge clk_48);
        chk("sa.addr_hold", 32'(dev_addr), 32'd0);
        status_done = 1'b1;
        chk("sa.addr_same_cycle", 32'(dev_addr), 32'd0);
        @(negedge clk_48);
        status_done = 1'b0;
        chk("sa.addr_applied", 32'(dev_addr), 32'h2A);
        status_done = 1'b1;
        @(negedge clk_48);
        status_done = 1'b0;
        chk("sa.no_pending", 32'(dev_addr), 32'h2A);

        // Three bytes then silence: timeout abandons the packet.
        nv = n_vpulse; ne = n_epulse;
        send_pkt(72'h80_06_00_00_00_00_00_00_00, 3, 1, 2);
        repeat (4700) @(negedge clk_48);
        chk("to.busy_before", 32'(busy), 32'd1);
        chk("to.no_early_err", 32'(n_epulse - ne), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk_48);
            if (req_err) seen = 1'b1;
        end
        chk("to.err_seen", 32'(seen), 32'd1);
        chk("to.busy_after", 32'(busy), 32'd0);
        chk("to.no_valid", 32'(n_vpulse - nv), 32'd0);
        chk_fields("to", 8'h00, 8'h05, 16'h002A, 16'h0000, 16'h0000);
        send_pkt(72'h80_06_00_02_00_00_09_00_00, 8, 1, 0);
        chk("to.next_valid", 32'(req_valid), 32'd1);
        chk_fields("to.next", 8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0009);
        chk("to.next_addr", 32'(dev_addr), 32'h2A);

        // Pending address is discarded by a bus reset.
        send_pkt(72'h00_05_15_00_00_00_00_00_00, 8, 1, 0);
        chk("ur.valid", 32'(req_valid), 32'd1);
        chk("ur.wv", 32'(w_value), 32'h0015);
        chk("ur.addr_before", 32'(dev_addr), 32'h2A);
        @(negedge clk_48);
        usb_rst = 1'b1;
        @(negedge clk_48);
        usb_rst = 1'b0;
        chk("ur.addr_cleared", 32'(dev_addr), 32'd0);
        chk_fields("ur", 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        status_done = 1'b1;
        @(negedge clk_48);
        status_done = 1'b0;
        @(negedge clk_48);
        chk("ur.addr_after_status", 32'(dev_addr), 32'd0);

        // rx_end in IDLE and non-SETUP strobes produce nothing.
        nv = n_vpulse; ne = n_epulse;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_48);
            setup     = 1'b0;
            rx_strobe = 1'b1;
            rx_data   = 8'(c);
            rx_end    = c[0];
            rx_crc_ok = 1'b1;
        end
        @(negedge clk_48);
        rx_strobe = 1'b0; rx_end = 1'b0; rx_crc_ok = 1'b0;
        repeat (2) @(negedge clk_48);
        chk("ig.no_valid", 32'(n_vpulse - nv), 32'd0);
        chk("ig.no_err", 32'(n_epulse - ne), 32'd0);
        chk("ig.busy", 32'(busy), 32'd0);
        chk("ig.fields", 32'(w_value), 32'd0);

        chk("never_both", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
